mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single SRAM-style memory bus between the fetch stage (I-side, read-only) and the memory stage (D-side, read/write).
- Supports split address/data handshakes with up to DEPTH transactions in flight, and returns each response to its owner in order.
- D-side has priority. A starvation counter guarantees I-side progress.
- An I-side flush (branch/exception redirect) discards fetch responses that are still in flight.

Parameters:
- DEPTH, 2, max outstanding accepted transactions (tag FIFO depth, power of 2, ≥1)
- STARVE_LIMIT, 4, consecutive I-side losses after which I-side wins the next grant

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch address (word aligned)
- i_flush  in  1  discard all outstanding and locked I-side transactions
- i_addr_ok  out  1  fetch request accepted this cycle
- i_data_ok  out  1  fetch data valid this cycle
- i_rdata  out  32  fetch data
- d_req  in  1  data request
- d_wr  in  1  1 = write
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_wstrb  in  4  byte enables
- d_addr_ok  out  1  data request accepted
- d_data_ok  out  1  read data valid / write done
- d_rdata  out  32  read data
- bus_req  out  1  request to memory
- bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb  out  1/2/32/32/4  request fields
- bus_addr_ok  in  1  memory accepted request
- bus_data_ok  in  1  memory response valid
- bus_rdata  in  32  response data

Behaviour:
- Reset (async): tag FIFO empty, lock cleared, starvation counter 0. All out ports read 0 while reset is held or when idle.
- Issue: bus_req = lock_valid | ((i_req|d_req) & !fifo_full).
- Owner selection when unlocked:
  - D-side if d_req and (starve_cnt < STARVE_LIMIT or !i_req); otherwise I-side.
  - I-side requests always drive bus_wr = 0, size = 2, wstrb = 0.
- Lock: if bus_req is high and bus_addr_ok is low, latch owner and all fields. The bus must then see identical fields every cycle until bus_addr_ok; the lock clears on that bus_addr_ok. A requester dropping req while locked does not cancel the locked request.
- Accept (bus_req & bus_addr_ok):
  - Push tag {owner, discard} into the FIFO.
  - Pulse i_addr_ok or d_addr_ok for exactly that cycle (combinational from bus_addr_ok). i_addr_ok is suppressed if discard = 1.
- Starvation counter:
  - Increments on a D-side accept while i_req is high (saturates at STARVE_LIMIT).
  - Clears on an I-side accept, or when i_req is low.
- Response (bus_data_ok):
  - Pop the FIFO head. If owner = D, d_data_ok = 1 and d_rdata = bus_rdata.
  - If owner = I and !discard, i_data_ok = 1 and i_rdata = bus_rdata.
  - If the head is discarded, both data_ok outputs stay 0.
- Same cycle accept and response: pop and push both happen; occupancy is unchanged. Full is evaluated before the pop, so no new request is issued when full, even if a pop occurs that cycle.
- i_flush (1 cycle):
  - Sets discard on every I-owned FIFO entry and on a locked I-side request.
  - An I response arriving in the flush cycle itself is discarded.
  - An I-side request presented unlocked in the flush cycle is not issued.
- bus_data_ok with the FIFO empty: ignored, no outputs asserted.
- Data outputs are 0 when their data_ok is low.

Decomposition:
- Shared package:
  - arb_owner_t enum {OWN_I, OWN_D}
  - arb_tag_t struct {owner, discard}
  - bus_req_t struct {wr, size, addr, wdata, wstrb}
  - size constants SZ_BYTE / SZ_HALF / SZ_WORD
- Sub-module arb_tag_fifo: DEPTH-entry circular FIFO of arb_tag_t.
  - Ports: push, pop, full, empty, head, plus a broadcast "mark all OWN_I discard" input.

Test Plan:
- I read at 0x1fc00000, memory addr_ok next cycle, data_ok 2 cycles later with 0x3c08bfaf -> i_addr_ok one pulse, i_data_ok one pulse with i_rdata = 0x3c08bfaf, d_* stay 0.
- i_req and d_req both high, bus_addr_ok always 1, data_ok 1 cycle later -> D granted 4 consecutive times, 5th grant to I, counter then 0.
- D write 0xdeadbeef, wstrb 0xF, to 0x80001000; bus_addr_ok held low 3 cycles while d_req drops after cycle 1 -> bus fields stable for all 4 cycles, a single accept, d_addr_ok at cycle 4.
- Two I reads accepted (FIFO full, DEPTH = 2), i_flush pulsed, then 2 data_ok -> no i_data_ok. bus_req stays low while full even with a pending d_req. D issues in the cycle after the first pop.
- I accepted, then D accepted, responses 0x11 and 0x22 -> i_rdata = 0x11 first, then d_rdata = 0x22. Same-cycle accept and response keeps occupancy constant.
- Assert reset with 2 outstanding and a lock held -> all outputs 0 immediately; after release, a stray bus_data_ok produces no data_ok.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter: owner tags, request fields, size codes.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        arb_owner_t owner;
        logic       discard;
    } arb_tag_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam bus_req_t BUS_IDLE = '0;

endpackage

// File: rtl/mem_bus_arbiter_arb_tag_fifo.sv
// Circular FIFO of in-flight transaction tags; one entry per accepted bus request,
// popped on each response. A broadcast input marks every I-owned entry as discarded.
module arb_tag_fifo
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  arb_tag_t push_tag_i,
    input  logic     pop_i,
    input  logic     mark_i_discard_i,
    output logic     full_o,
    output logic     empty_o,
    output arb_tag_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    arb_tag_t [DEPTH-1:0] mem_q;
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (mark_i_discard_i) begin
                for (int i = 0; i < DEPTH; i++)
                    if (mem_q[i].owner == OWN_I) mem_q[i].discard <= 1'b1;
            end
            // The pushed tag already carries its own discard bit and must win over the mark.
            if (do_push) begin
                mem_q[wr_q] <= push_tag_i;
                wr_q        <= inc(wr_q);
            end
            if (do_pop) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one split-handshake memory bus between fetch (I) and memory stage (D):
// D priority with starvation relief, request lock until accept, in-order responses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic       lock_q, lock_d;
    arb_owner_t lock_own_q, lock_own_d;
    logic       lock_disc_q, lock_disc_d;
    bus_req_t   lock_req_q, lock_req_d;
    logic [SCW-1:0] starve_q, starve_d;

    arb_tag_t   head;
    logic       fifo_full, fifo_empty;
    logic       i_go, issue, accept, cur_disc, pop, head_disc;
    arb_owner_t own;
    bus_req_t   req_f, i_fields, d_fields;

    // A fetch presented in a flush cycle belongs to the redirected-away stream.
    assign i_go = i_req & ~i_flush;

    always_comb begin
        i_fields = '{wr: 1'b0, size: SZ_WORD, addr: i_addr, wdata: '0, wstrb: '0};
        d_fields = '{wr: d_wr, size: d_size, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
        own      = OWN_I;
        if (lock_q)
            own = lock_own_q;
        else if (d_req && (starve_q < SCW'(STARVE_LIMIT) || !i_go))
            own = OWN_D;
        req_f    = lock_q ? lock_req_q : ((own == OWN_D) ? d_fields : i_fields);
        issue    = ~reset & (lock_q | ((i_go | d_req) & ~fifo_full));
        accept   = issue & bus_addr_ok;
        cur_disc = (own == OWN_I) & lock_q & (lock_disc_q | i_flush);
    end

    always_comb begin
        lock_d      = lock_q;
        lock_own_d  = lock_own_q;
        lock_req_d  = lock_req_q;
        lock_disc_d = lock_disc_q;
        if (accept) begin
            lock_d      = 1'b0;
            lock_disc_d = 1'b0;
        end else if (issue && !lock_q) begin
            lock_d      = 1'b1;
            lock_own_d  = own;
            lock_req_d  = req_f;
            lock_disc_d = 1'b0;
        end else if (lock_q && i_flush && lock_own_q == OWN_I) begin
            lock_disc_d = 1'b1;
        end

        starve_d = starve_q;
        if (!i_req)
            starve_d = '0;
        else if (accept && own == OWN_I)
            starve_d = '0;
        else if (accept && own == OWN_D && starve_q < SCW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q      <= 1'b0;
            lock_own_q  <= OWN_I;
            lock_req_q  <= BUS_IDLE;
            lock_disc_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_own_q  <= lock_own_d;
            lock_req_q  <= lock_req_d;
            lock_disc_q <= lock_disc_d;
            starve_q    <= starve_d;
        end
    end

    arb_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk_i            (clk),
        .rst_i            (reset),
        .push_i           (accept),
        .push_tag_i       ('{owner: own, discard: cur_disc}),
        .pop_i            (pop),
        .mark_i_discard_i (i_flush),
        .full_o           (fifo_full),
        .empty_o          (fifo_empty),
        .head_o           (head)
    );

    assign pop       = ~reset & bus_data_ok & ~fifo_empty;
    assign head_disc = head.discard | ((head.owner == OWN_I) & i_flush);

    always_comb begin
        bus_req = issue;
        {bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb} = issue ? req_f : BUS_IDLE;
        i_addr_ok = accept & (own == OWN_I) & ~cur_disc;
        d_addr_ok = accept & (own == OWN_D);
        i_data_ok = pop & (head.owner == OWN_I) & ~head_disc;
        d_data_ok = pop & (head.owner == OWN_D);
        i_rdata   = i_data_ok ? bus_rdata : '0;
        d_rdata   = d_data_ok ? bus_rdata : '0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-by-cycle vector bench for mem_bus_arbiter with an expected-result queue.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0, reset = 1'b0;
    logic        i_req, i_flush, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        rst, ireq, fl, dreq, dwr;
        logic [1:0]  dsz;
        logic [31:0] iaddr, daddr, wdata;
        logic [3:0]  wstrb;
        logic        aok, dok;
        logic [31:0] rd;
    } in_t;

    typedef struct packed {
        logic        breq, bwr;
        logic [1:0]  bsz;
        logic [31:0] baddr, bwdata;
        logic [3:0]  bwstrb;
        logic        iaok, idok;
        logic [31:0] irdata;
        logic        daok, ddok;
        logic [31:0] drdata;
    } out_t;

    typedef struct {
        string nm;
        in_t   in;
        out_t  ex;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0, n_err = 0;

    // Current stimulus fields (c_*) and the D request the bus is expected to show (e_*).
    logic        c_rst = 1'b0, c_dwr = 1'b0, e_dwr = 1'b0;
    logic [1:0]  c_dsz = 2'd2, e_dsz = 2'd2;
    logic [31:0] c_iaddr = '0, c_daddr = '0, c_wdata = '0, e_daddr = '0, e_wdata = '0;
    logic [3:0]  c_wstrb = '0, e_wstrb = '0;

    task automatic setd(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s);
        c_dwr = wr; c_dsz = sz; c_daddr = a; c_wdata = w; c_wstrb = s;
        e_dwr = wr; e_dsz = sz; e_daddr = a; e_wdata = w; e_wstrb = s;
    endtask

    task automatic add(input string nm, input int ireq, input int fl, input int dreq,
                       input int aok, input int dok, input logic [31:0] rd,
                       input int breq, input int own_d, input int iaok, input int idok,
                       input int daok, input int ddok);
        vec_t v;
        v.nm = nm;
        v.in = '{c_rst, 1'(ireq), 1'(fl), 1'(dreq), c_dwr, c_dsz, c_iaddr, c_daddr,
                 c_wdata, c_wstrb, 1'(aok), 1'(dok), rd};
        v.ex = '0;
        v.ex.breq = 1'(breq);
        if (breq != 0) begin
            if (own_d != 0)
                {v.ex.bwr, v.ex.bsz, v.ex.baddr, v.ex.bwdata, v.ex.bwstrb} =
                    {e_dwr, e_dsz, e_daddr, e_wdata, e_wstrb};
            else
                {v.ex.bwr, v.ex.bsz, v.ex.baddr, v.ex.bwdata, v.ex.bwstrb} =
                    {1'b0, 2'd2, c_iaddr, 32'h0, 4'h0};
        end
        v.ex.iaok   = 1'(iaok);
        v.ex.idok   = 1'(idok);
        v.ex.irdata = (idok != 0) ? rd : 32'h0;
        v.ex.daok   = 1'(daok);
        v.ex.ddok   = 1'(ddok);
        v.ex.drdata = (ddok != 0) ? rd : 32'h0;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t x);
        reset = x.rst; i_req = x.ireq; i_flush = x.fl; i_addr = x.iaddr;
        d_req = x.dreq; d_wr = x.dwr; d_size = x.dsz; d_addr = x.daddr;
        d_wdata = x.wdata; d_wstrb = x.wstrb;
        bus_addr_ok = x.aok; bus_data_ok = x.dok; bus_rdata = x.rd;
    endtask

    function automatic out_t got();
        return '{bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
                 i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata};
    endfunction

    task automatic check();
        vec_t v;
        out_t g;
        v = sb.pop_front();
        g = got();
        n_vec++;
        if (g !== v.ex) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", v.nm, g, v.ex);
        end
    endtask

    initial begin
        int  nd;
        bit  seen;
        //                      ireq fl dreq aok dok rd          breq ownD iaok idok daok ddok
        c_rst = 1'b1;
        add("rst_hold",          1, 0, 1,   1,  1,  32'h1,       0, 0, 0, 0, 0, 0);
        c_rst = 1'b0;
        add("idle",              0, 0, 0,   0,  0,  32'h0,       0, 0, 0, 0, 0, 0);
        // single fetch with late addr_ok and data_ok
        c_iaddr = 32'h1fc00000;
        add("A0_req",            1, 0, 0,   0,  0,  32'h0,       1, 0, 0, 0, 0, 0);
        add("A1_acc",            1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("A2_wait",           0, 0, 0,   0,  0,  32'h0,       0, 0, 0, 0, 0, 0);
        add("A3_data",           0, 0, 0,   0,  1,  32'h3c08bfaf, 0, 0, 0, 1, 0, 0);
        // starvation: four D grants, then I
        setd(1'b0, SZ_WORD, 32'h80000000, 32'h0, 4'h0);
        add("B0_d",              1, 0, 1,   1,  0,  32'h0,       1, 1, 0, 0, 1, 0);
        add("B1_d",              1, 0, 1,   1,  1,  32'hd1,      1, 1, 0, 0, 1, 1);
        add("B2_d",              1, 0, 1,   1,  1,  32'hd2,      1, 1, 0, 0, 1, 1);
        add("B3_d",              1, 0, 1,   1,  1,  32'hd3,      1, 1, 0, 0, 1, 1);
        add("B4_i_wins",         1, 0, 1,   1,  1,  32'hd4,      1, 0, 1, 0, 0, 1);
        add("B5_d_again",        1, 0, 1,   1,  1,  32'hd5,      1, 1, 0, 1, 1, 0);
        add("B6_drain",          0, 0, 0,   0,  1,  32'hd6,      0, 0, 0, 0, 0, 1);
        // locked D write survives d_req drop and changed inputs
        setd(1'b1, SZ_WORD, 32'h80001000, 32'hdeadbeef, 4'hf);
        add("C0_lock",           0, 0, 1,   0,  0,  32'h0,       1, 1, 0, 0, 0, 0);
        c_dwr = 1'b0; c_daddr = 32'h12345678; c_wdata = 32'h0; c_wstrb = 4'h0;
        add("C1_hold",           0, 0, 0,   0,  0,  32'h0,       1, 1, 0, 0, 0, 0);
        add("C2_hold",           0, 0, 0,   0,  0,  32'h0,       1, 1, 0, 0, 0, 0);
        add("C3_acc",            0, 0, 0,   1,  0,  32'h0,       1, 1, 0, 0, 1, 0);
        add("C4_done",           0, 0, 0,   0,  1,  32'h55,      0, 0, 0, 0, 0, 1);
        // full FIFO, flush, discarded responses, D issues after first pop
        c_iaddr = 32'h1fc00010;
        setd(1'b0, SZ_WORD, 32'h80002000, 32'h0, 4'h0);
        add("D0_i1",             1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("D1_i2",             1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("D2_full_flush",     0, 1, 1,   1,  0,  32'h0,       0, 0, 0, 0, 0, 0);
        add("D3_full_pop",       0, 0, 1,   1,  1,  32'haa,      0, 0, 0, 0, 0, 0);
        add("D4_d_issue",        0, 0, 1,   1,  1,  32'hbb,      1, 1, 0, 0, 1, 0);
        add("D5_d_data",         0, 0, 0,   0,  1,  32'hcc,      0, 0, 0, 0, 0, 1);
        // ordering and same-cycle push/pop
        c_iaddr = 32'h1fc00020;
        setd(1'b0, SZ_WORD, 32'h80003000, 32'h0, 4'h0);
        add("E0_i",              1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("E1_d",              0, 0, 1,   1,  0,  32'h0,       1, 1, 0, 0, 1, 0);
        add("E2_i_data",         0, 0, 0,   0,  1,  32'h11,      0, 0, 0, 1, 0, 0);
        add("E3_pushpop",        0, 0, 1,   1,  1,  32'h22,      1, 1, 0, 0, 1, 1);
        add("E4_pushpop",        0, 0, 1,   1,  1,  32'h33,      1, 1, 0, 0, 1, 1);
        add("E5_drain",          0, 0, 0,   0,  1,  32'h44,      0, 0, 0, 0, 0, 1);
        add("E6_stray",          0, 0, 0,   0,  1,  32'h99,      0, 0, 0, 0, 0, 0);
        // flush corners: response in flush cycle, locked I request flushed
        c_iaddr = 32'h1fc00030;
        add("F0_i",              1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("F1_flush_resp",     1, 1, 0,   0,  1,  32'h77,      0, 0, 0, 0, 0, 0);
        add("F2_i_lock",         1, 0, 0,   0,  0,  32'h0,       1, 0, 0, 0, 0, 0);
        add("F3_flush_locked",   1, 1, 0,   0,  0,  32'h0,       1, 0, 0, 0, 0, 0);
        add("F4_acc_silent",     0, 0, 0,   1,  0,  32'h0,       1, 0, 0, 0, 0, 0);
        add("F5_resp_silent",    0, 0, 0,   0,  1,  32'h88,      0, 0, 0, 0, 0, 0);
        // reset with an entry outstanding and a D half-write locked
        c_iaddr = 32'h1fc00040;
        setd(1'b1, SZ_HALF, 32'h80004002, 32'h0000abcd, 4'h3);
        add("R0_i",              1, 0, 0,   1,  0,  32'h0,       1, 0, 1, 0, 0, 0);
        add("R1_d_lock",         0, 0, 1,   0,  0,  32'h0,       1, 1, 0, 0, 0, 0);
        c_rst = 1'b1;
        add("R2_reset",          1, 0, 1,   1,  1,  32'h5,       0, 0, 0, 0, 0, 0);
        c_rst = 1'b0;
        add("R3_stray",          0, 0, 0,   0,  1,  32'h6,       0, 0, 0, 0, 0, 0);

        drive('0);
        #1 reset = 1'b1;
        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].in);
            sb.push_back(tbl[k]);
            #2 check();
        end

        // Free-running contention: count D grants before the first I grant.
        nd = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            reset = 1'b0; i_req = 1'b1; i_flush = 1'b0; d_req = 1'b1;
            bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'(k);
            #2;
            if (d_addr_ok) nd++;
            if (i_addr_ok) seen = 1'b1;
        end
        n_vec++;
        if (!seen || nd != 4) begin
            n_err++;
            $display("FAIL starve_loop: got d_grants=%0d i_granted=%0d expected d_grants=4 i_granted=1",
                     nd, seen);
        end

        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        bus_rdata = 32'hface;
        #2;
        n_vec++;
        if ({i_data_ok, i_rdata, d_data_ok} !== {1'b1, 32'hface, 1'b0}) begin
            n_err++;
            $display("FAIL starve_drain: got i_data_ok=%b i_rdata=%h d_data_ok=%b expected 1 0000face 0",
                     i_data_ok, i_rdata, d_data_ok);
        end

        @(negedge clk);
        bus_data_ok = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
